// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART command controller.
// Latency: n/a (package only).
// Backpressure: n/a; holds command codes, FSM states and frame length helper.
package uart_ctrl_pkg;

  // ASCII command bytes
  localparam logic [7:0] CMD_GO     = 8'h47;  // 'G' run counter
  localparam logic [7:0] CMD_HALT   = 8'h48;  // 'H' stop counter
  localparam logic [7:0] CMD_CLEAR  = 8'h43;  // 'C' clear counter
  localparam logic [7:0] CMD_QUERY  = 8'h51;  // 'Q' send count, MSB first
  localparam logic [7:0] CMD_ERRCLR = 8'h45;  // 'E' clear sticky flags

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    ECHO_TX   = 3'd2,
    ECHO_WAIT = 3'd3,
    RESP_TX   = 3'd4,
    RESP_WAIT = 3'd5
  } state_t;

  // Cycles between consecutive transmit start pulses: 10 bits per frame
  // (start + 8 data + stop) plus idle guard cycles.
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input int unsigned guard_cycles);
    return 10 * clks_per_bit + guard_cycles;
  endfunction

endpackage

// File: rtl/uart_cmd_controller_timer.sv
// tx_frame_timer: loadable down-counter pacing transmit start pulses.
// Latency: o_done pulses for one cycle in the first cycle the count reads zero,
//          i.e. i_value+1 cycles after the load cycle. Backpressure: none.
// Ports: clk, i_reset_n (async low), i_load, i_value, o_done.
module tx_frame_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (i_load) begin
      cnt_d = i_value;
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - WIDTH'(1);
      // Registered so the pulse coincides with the zero count.
      done_d = (cnt_q == WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign o_done = done_q;

endmodule

// File: rtl/uart_cmd_controller.sv
// uart_cmd_controller: decodes single-byte ASCII commands from the UART
// receiver, drives counter enable/clear, and shares one transmitter between
// command echo and 4-byte count responses, pacing start pulses by time.
// Latency: effects and first o_tx_start 2 edges after the valid-edge sample.
// Backpressure: 1-deep hold register; a byte arriving while it is full is
// dropped and flagged on o_overrun.
// Ports: clk, i_reset_n, i_rx_data/i_rx_valid (RX), i_count (counter value),
//        o_count_enable/o_count_clear (counter), o_tx_data/o_tx_start/
//        o_tx_busy (TX), o_err/o_overrun (sticky flags).
module uart_cmd_controller
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned ECHO_EN      = 1
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic [31:0] i_count,
  output logic        o_count_enable,
  output logic        o_count_clear,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  output logic        o_tx_busy,
  output logic        o_err,
  output logic        o_overrun
);

  localparam int unsigned FRAME = frame_cycles(CLKS_PER_BIT, GUARD_CYCLES);
  localparam int unsigned TW    = $clog2(FRAME + 1);
  // One TX cycle + (load value + 1) wait cycles = FRAME cycles per start.
  localparam logic [TW-1:0] WAIT_LOAD = TW'(FRAME - 2);

  state_t      state_q, state_d;
  logic        rx_prev_q;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] snap_q, snap_d;
  logic [1:0]  idx_q, idx_d;
  logic        enable_q, enable_d;
  logic        clear_q, clear_d;
  logic        err_q, err_d;
  logic        overrun_q, overrun_d;

  logic        rx_rise;
  logic        timer_load;
  logic        timer_done;
  logic [7:0]  resp_byte;

  assign rx_rise = i_rx_valid & ~rx_prev_q;

  tx_frame_timer #(.WIDTH(TW)) u_timer (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_load    (timer_load),
    .i_value   (WAIT_LOAD),
    .o_done    (timer_done)
  );

  // State register
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (hold_full_q) state_d = DECODE;
      DECODE: begin
        if (ECHO_EN != 0)            state_d = ECHO_TX;
        else if (cmd_q == CMD_QUERY) state_d = RESP_TX;
        else                         state_d = IDLE;
      end
      ECHO_TX:   state_d = ECHO_WAIT;
      ECHO_WAIT: if (timer_done) state_d = (cmd_q == CMD_QUERY) ? RESP_TX : IDLE;
      RESP_TX:   state_d = RESP_WAIT;
      RESP_WAIT: if (timer_done) state_d = (idx_q == 2'd3) ? IDLE : RESP_TX;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    case (idx_q)
      2'd0:    resp_byte = snap_q[31:24];
      2'd1:    resp_byte = snap_q[23:16];
      2'd2:    resp_byte = snap_q[15:8];
      default: resp_byte = snap_q[7:0];
    endcase
    o_tx_start = 1'b0;
    o_tx_busy  = 1'b0;
    o_tx_data  = 8'h00;
    timer_load = 1'b0;
    case (state_q)
      ECHO_TX:   begin o_tx_start = 1'b1; o_tx_busy = 1'b1; o_tx_data = cmd_q; timer_load = 1'b1; end
      ECHO_WAIT: begin o_tx_busy = 1'b1; o_tx_data = cmd_q; end
      RESP_TX:   begin o_tx_start = 1'b1; o_tx_busy = 1'b1; o_tx_data = resp_byte; timer_load = 1'b1; end
      RESP_WAIT: begin o_tx_busy = 1'b1; o_tx_data = resp_byte; end
      default:   ;
    endcase
  end

  // Datapath: hold register, command decode, flags
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cmd_d       = cmd_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    enable_d    = enable_q;
    clear_d     = 1'b0;
    err_d       = err_q;
    overrun_d   = overrun_q;

    if ((state_q == IDLE) && hold_full_q) begin
      cmd_d       = hold_q;
      hold_full_d = 1'b0;
    end

    if (state_q == DECODE) begin
      idx_d = 2'd0;
      case (cmd_q)
        CMD_GO:     enable_d = 1'b1;
        CMD_HALT:   enable_d = 1'b0;
        CMD_CLEAR:  clear_d  = 1'b1;
        CMD_QUERY:  snap_d   = i_count;
        CMD_ERRCLR: begin err_d = 1'b0; overrun_d = 1'b0; end
        default:    err_d    = 1'b1;
      endcase
    end

    if ((state_q == RESP_WAIT) && timer_done) idx_d = idx_q + 2'd1;

    // A full hold register drops the new byte even if it drains this cycle.
    // Placed after the decode so an overrun beats a same-cycle 'E' clear.
    if (rx_rise) begin
      if (hold_full_q) begin
        overrun_d = 1'b1;
      end else begin
        hold_d      = i_rx_data;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_prev_q   <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      cmd_q       <= 8'h00;
      snap_q      <= 32'h0;
      idx_q       <= 2'd0;
      enable_q    <= 1'b0;
      clear_q     <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_prev_q   <= i_rx_valid;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cmd_q       <= cmd_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      enable_q    <= enable_d;
      clear_q     <= clear_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_count_enable = enable_q;
  assign o_count_clear  = clear_q;
  assign o_err          = err_q;
  assign o_overrun      = overrun_q;

endmodule

// File: doc/uart_cmd_controller.md
Name: uart_cmd_controller

Overview:
Sequences the UART datapath. It takes bytes from uart_receiver and decodes single-byte ASCII commands that run, halt, clear and query the up counter. It shares one uart_transmitter between command echo and count-query responses. It sits in counter_top between uart_receiver, counter and uart_transmitter; the transmitter has no busy output, so this block paces its start pulses by time.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit; must match the transmitter.
GUARD_CYCLES, 2, idle cycles added after each frame.
ECHO_EN, 1, 1 = echo every accepted byte before acting on it.

Ports:
clk  input  1  system clock (clk_gen domain)
i_reset_n  input  1  asynchronous, active-low reset
i_rx_data  input  8  received byte (uart_receiver o_data)
i_rx_valid  input  1  uart_receiver o_ready_to_read; level or pulse accepted
i_count  input  32  live counter value
o_count_enable  output  1  counter run enable (level)
o_count_clear  output  1  one-cycle counter clear pulse
o_tx_data  output  8  byte to transmit; held stable while o_tx_busy
o_tx_start  output  1  one-cycle transmit start pulse
o_tx_busy  output  1  high while a frame is in flight
o_err  output  1  sticky flag: unknown command received
o_overrun  output  1  sticky flag: byte dropped

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, hold register empty, timer 0.
- RX capture: a byte is accepted on the rising edge of i_rx_valid, i.e. sampled 1 when the previous sample was 0. The byte loads a 1-deep hold register.
- If the hold register is full on a new edge, the byte is dropped and o_overrun is set. The hold register refills whenever it is empty, including during transmission, so one command can queue.
- Command set (ASCII):
  - 'G' 0x47: o_count_enable = 1.
  - 'H' 0x48: o_count_enable = 0.
  - 'C' 0x43: one o_count_clear pulse; enable unchanged.
  - 'Q' 0x51: snapshot i_count, then send 4 bytes, MSB first ([31:24] first).
  - 'E' 0x45: clear o_err and o_overrun.
  - Any other byte: set o_err; no other action.
- FSM states: IDLE, DECODE, ECHO_TX, ECHO_WAIT, RESP_TX, RESP_WAIT.
  - IDLE -> DECODE when the hold register is full; the byte moves to the command register and the hold register empties.
  - DECODE:
    - Commits the command's effect and the 'Q' snapshot.
    - With ECHO_EN = 1 -> ECHO_TX for every accepted byte (including unknown ones).
    - With ECHO_EN = 0 -> RESP_TX for 'Q', else IDLE.
  - ECHO_TX: o_tx_data = command byte, o_tx_start pulse, -> ECHO_WAIT.
  - ECHO_WAIT: on timer done -> RESP_TX for 'Q', else IDLE.
  - RESP_TX/RESP_WAIT: four iterations with byte index 0..3; after index 3 completes -> IDLE.
- Latency: command effects, the snapshot and the first o_tx_start are registered and appear 2 clock edges after the edge that samples the valid rising edge.
- Pacing: FRAME = 10*CLKS_PER_BIT + GUARD_CYCLES.
  - Consecutive o_tx_start pulses are exactly FRAME cycles apart.
  - o_tx_busy rises with o_tx_start and falls when the last wait expires.
- Flag collisions: if an overrun set and an 'E' clear happen in the same cycle, the set wins.
- The 'Q' snapshot is stable; counter changes during the response are not reflected.
- Reset mid-operation: everything returns to reset values immediately. The transmitter must share i_reset_n so a partial frame is aborted.

Decomposition:
- Package uart_ctrl_pkg: command byte localparams (CMD_GO, CMD_HALT, CMD_CLEAR, CMD_QUERY, CMD_ERRCLR), state_t enum, frame_cycles() function.
- Sub-module tx_frame_timer: loadable down-counter with input i_load and output o_done (one-cycle pulse at zero), width $clog2(FRAME+1).

Test Plan:
- Sim with CLKS_PER_BIT=4, GUARD_CYCLES=2 (FRAME=42). Reset then 'G' -> o_count_enable=1 two edges after valid edge. Echo o_tx_data=0x47 with one o_tx_start, then o_tx_busy high for 42 cycles.
- i_count=32'h12345678, send 'Q' -> five start pulses 42 cycles apart carrying 0x51, 0x12, 0x34, 0x56, 0x78. Changing i_count mid-response has no effect on the bytes.
- Send 'Q', then 'C' and 'H' during the response -> 'C' queues in the hold register and executes after the response; 'H' is dropped, o_overrun=1. A following 'E' -> o_err=0, o_overrun=0.
- Send 0x7A -> o_err=1, echo 0x7A, o_count_enable unchanged. Then 'C' -> exactly one o_count_clear cycle.
- Hold i_rx_valid high for 10 cycles with 'G' -> exactly one command accepted, one echo.
- Pull i_reset_n low during the 3rd response byte -> all outputs 0 immediately. After release, send 'G' -> normal operation.
